// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a program image over an 8N1 serial line and
// writes it into main memory through the manual-entry inputs (D, A1).
// The CPU is held in program-load mode during the load and then released
// into run mode. A frame is the header byte 0xA5, then a length byte N
// (0 means 256), then N data bytes.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int A1_PULSE     = 4,
    parameter int A1_GAP       = 4,
    parameter int SETTLE       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       abort,
    output logic [7:0] D,
    output logic       A1,
    output logic       SW1,
    output logic       SW2,
    output logic [8:0] byte_cnt,
    output logic       busy,
    output logic       frame_err,
    output logic       done
);

    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST   = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] PULSE_LAST  = 16'(A1_PULSE - 1);
    localparam logic [15:0] GAP_LAST    = 16'(A1_GAP - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    localparam logic [7:0] HEADER = 8'hA5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LEN       = 3'd1;
    localparam logic [2:0] S_DATA_WAIT = 3'd2;
    localparam logic [2:0] S_WR_SETUP  = 3'd3;
    localparam logic [2:0] S_WR_PULSE  = 3'd4;
    localparam logic [2:0] S_WR_GAP    = 3'd5;
    localparam logic [2:0] S_SETTLE    = 3'd6;
    localparam logic [2:0] S_RUN       = 3'd7;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_timer;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_valid;
    logic        rx_ferr;

    logic [2:0]  state;
    logic [15:0] timer;
    logic [8:0]  target;
    logic [1:0]  mode;

    assign SW1 = mode[1];
    assign SW2 = mode[0];

    // Bring the asynchronous serial line into the clk domain and keep one
    // extra delayed copy so a falling edge can be detected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // 8N1 receiver: half-bit start check rejects glitches, data is sampled
    // LSB first at bit centres, and the stop bit decides good byte vs error.
    // rx_shift holds the received byte while rx_valid is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_timer <= '0;
                    end
                end
                RX_START: begin
                    if (rx_timer == HALF_LAST) begin
                        rx_timer <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_timer <= rx_timer + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_timer <= rx_timer + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_timer <= rx_timer + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Loader sequencing: header, length, then one D setup cycle, an A1 pulse
    // and a gap per byte, a settle period and finally run mode. Abort wins
    // over everything else; bytes arriving mid-write are flagged as overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            target    <= '0;
            mode      <= MODE_STOP;
            D         <= '0;
            A1        <= 1'b0;
            byte_cnt  <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            timer <= '0;
            mode  <= MODE_STOP;
            A1    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            if (rx_ferr) begin
                frame_err <= 1'b1;
            end
        end else begin
            if (rx_ferr) begin
                frame_err <= 1'b1;
            end
            case (state)
                S_IDLE, S_RUN: begin
                    if (rx_valid && rx_shift == HEADER) begin
                        state     <= S_LEN;
                        mode      <= MODE_LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        frame_err <= 1'b0;
                        byte_cnt  <= '0;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        target <= (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
                        state  <= S_DATA_WAIT;
                    end
                end
                S_DATA_WAIT: begin
                    if (rx_valid) begin
                        D     <= rx_shift;
                        state <= S_WR_SETUP;
                    end
                end
                S_WR_SETUP: begin
                    A1    <= 1'b1;
                    timer <= '0;
                    state <= S_WR_PULSE;
                    if (rx_valid) begin
                        frame_err <= 1'b1;
                    end
                end
                S_WR_PULSE: begin
                    if (rx_valid) begin
                        frame_err <= 1'b1;
                    end
                    if (timer == PULSE_LAST) begin
                        A1       <= 1'b0;
                        byte_cnt <= byte_cnt + 9'd1;
                        timer    <= '0;
                        state    <= S_WR_GAP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_WR_GAP: begin
                    if (rx_valid) begin
                        frame_err <= 1'b1;
                    end
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        state <= (byte_cnt == target) ? S_SETTLE : S_DATA_WAIT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        mode  <= MODE_RUN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_RUN;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream front end for the complex CPU top level. It receives a program image over a serial 8N1 line and writes it into main memory.
- It does this by driving the memory's manual-entry inputs (D, A1) while holding the CPU in program-load state through SW1/SW2.
- After the last byte it switches the CPU to run state. This replaces hand-keying on switches.
- It sits between the board UART pin and the top-level inputs D, A1, SW1 and SW2.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Minimum 8.
- A1_PULSE, 4: clk cycles A1 is held high per written byte.
- A1_GAP, 4: clk cycles A1 is held low after each pulse, with D still stable.
- SETTLE, 8: clk cycles held in load state after the last write, before run is asserted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- rxd  in  1  serial input; idles high; asynchronous to clk.
- abort  in  1  synchronous, active-high. Returns the block to IDLE.
- D  out  8  byte presented to memory manual-entry input.
- A1  out  1  memory write/advance strobe.
- SW1  out  1  CPU mode select, high bit.
- SW2  out  1  CPU mode select, low bit.
- byte_cnt  out  9  data bytes written since the last header.
- busy  out  1  high from header accepted until run asserted.
- frame_err  out  1  sticky framing or overrun error.
- done  out  1  high while in RUN.

Behaviour:
- Mode encoding {SW1,SW2}:
  - 2'b00: CPU idle/stop.
  - 2'b01: program load.
  - 2'b11: run.
  - 2'b10 is never driven.
- Reset (rst low, async): D=0, A1=0, {SW1,SW2}=00, byte_cnt=0, busy=0, frame_err=0, done=0. FSM goes to IDLE and the receiver goes to RX_IDLE. A reset mid-pulse drops A1 immediately.
- Receiver:
  - rxd passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the edge was a glitch and the receiver returns to RX_IDLE.
  - Data bits are sampled LSB first at each bit centre. The stop bit is sampled at its centre.
  - A stop bit of 0 sets frame_err and the byte is discarded.
  - A good byte raises rx_valid for 1 cycle, at the stop-bit centre plus 1 cycle.
- Loader FSM:
  - IDLE: outputs 00. On a valid byte 0xA5, go to LEN; any other byte is ignored. On entry to LEN: busy=1, frame_err=0, byte_cnt=0, {SW1,SW2}=01.
  - LEN: next valid byte is N. N=0 means 256 bytes. Go to DATA_WAIT.
  - DATA_WAIT: on a valid byte, D<=byte in the same cycle as rx_valid. On the next cycle A1=1 and the FSM enters WR_PULSE.
  - WR_PULSE: lasts A1_PULSE cycles, then A1=0 and go to WR_GAP. byte_cnt increments on the A1 falling edge.
  - WR_GAP: lasts A1_GAP cycles. If byte_cnt==N (256 when N=0), go to SETTLE; else go to DATA_WAIT.
  - SETTLE: lasts SETTLE cycles, still in mode 01. Then {SW1,SW2}=11, done=1, busy=0, go to RUN.
  - RUN: holds until abort or a new 0xA5 header byte. A new header re-enters LEN with mode 01.
- Simultaneous and boundary events:
  - A rx_valid arriving in WR_PULSE or WR_GAP is an overrun: set frame_err and drop that byte. The pulse in progress completes normally. This cannot occur when CLKS_PER_BIT*10 > A1_PULSE+A1_GAP+2.
  - A framing error during LEN or data: frame_err=1, FSM state unchanged. The load continues and the host resends.
  - abort has priority over rx_valid in the same cycle. It forces A1=0, mode 00, busy=0 and state IDLE. frame_err is retained.
- D holds its last written value except under reset.

Test Plan:
- Reset with rxd idle-high: all outputs 0, mode 00. Send bytes A5,03,11,22,33 at CLKS_PER_BIT=16 → exactly three A1 pulses, each 4 cycles wide. D=0x11/0x22/0x33 is stable from 1 cycle before each rising edge until the next byte. byte_cnt=3. SW=01 throughout the load, then 8 cycles later SW=11 and done=1.
- Header 0xA5 then length 0x00 followed by 256 bytes 0x00..0xFF → 256 A1 pulses and byte_cnt=256, then done.
- Frame with a stop bit of 0 during the data phase → frame_err=1 and no A1 pulse for that byte. The following good byte is written, and byte_cnt counts only good bytes.
- 1-cycle-wide low glitch on rxd in IDLE → no rx_valid and no state change.
- Assert abort mid-WR_PULSE → A1 drops next cycle, SW=00, busy=0. A fresh A5,01,7E afterwards → single write of 0x7E, then run.
- Async rst pulse while A1=1 → A1 and SW go to 0 immediately, without waiting for a clk edge.
